// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with a registered result and flags (zero/less/ovf/err).
// MUL uses an iterative shift-add engine, compiled in only when SEQ_ALU_MUL_EN is defined.
module seq_alu #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             less,
  output logic             ovf,
  output logic             err
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1100;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t                  state_q;
  logic [WIDTH-1:0]        out_q;
  logic                    zero_q, less_q, ovf_q, err_q;
  logic                    accept;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        sum, diff, res_d;
  logic [SHW-1:0]          shamt;
  logic                    lt, res_less, res_ovf, res_err;

  assign a_s   = in1;
  assign b_s   = in2;
  assign sum   = in1 + in2;
  assign diff  = in1 - in2;
  assign shamt = in2[SHW-1:0];
  // true signed compare; the sign of diff is wrong whenever the subtraction overflows
  assign lt    = a_s < b_s;

`ifdef SEQ_ALU_MUL_EN
  logic                    is_mul;
  logic [WIDTH-1:0]        mcand_q, mplier_q, acc_q, acc_d;
  logic [SHW-1:0]          cnt_q;
  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
`endif

  always_comb begin
    res_d    = '0;
    res_less = 1'b0;
    res_ovf  = 1'b0;
    res_err  = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    is_mul   = 1'b0;
`endif
    case (alu_op)
      OP_AND: res_d = in1 & in2;
      OP_OR:  res_d = in1 | in2;
      OP_XOR: res_d = in1 ^ in2;
      OP_ADD: begin
        res_d   = sum;
        res_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        res_d    = diff;
        res_less = lt;
        res_ovf  = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SLT: begin
        res_d    = {{(WIDTH-1){1'b0}}, lt};
        res_less = lt;
      end
      OP_SRL: res_d = in1 >> shamt;
      OP_SRA: res_d = a_s >>> shamt;
      OP_SLL: res_d = in1 << shamt;
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: is_mul = 1'b1;
`endif
      default: res_err = 1'b1;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign zero      = zero_q;
  assign less      = less_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      zero_q   <= 1'b0;
      less_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
`ifdef SEQ_ALU_MUL_EN
            if (is_mul) begin
              state_q  <= S_BUSY;
              mcand_q  <= in1;
              mplier_q <= in2;
              acc_q    <= '0;
              cnt_q    <= '0;
            end else
`endif
            begin
              state_q <= S_DONE;
              out_q   <= res_d;
              zero_q  <= (res_d == '0);
              less_q  <= res_less;
              ovf_q   <= res_ovf;
              err_q   <= res_err;
            end
          end else if ((state_q == S_DONE) && out_ready) begin
            state_q <= S_IDLE;
          end
        end
`ifdef SEQ_ALU_MUL_EN
        // one shift-add step per cycle; the last step lands the product directly in out_q
        S_BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SHW'(1);
          if (cnt_q == SHW'(WIDTH-1)) begin
            state_q <= S_DONE;
            out_q   <= acc_d;
            zero_q  <= (acc_d == '0);
            less_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=64): directed scenarios plus randomized ops
// checked against an arithmetic reference model; MUL expectations follow SEQ_ALU_MUL_EN.
module tb_seq_alu;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   alu_op = 4'd0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         in_ready, out_valid, zero, less, ovf, err;
  logic [W-1:0] out;

  int n_chk = 0;
  int n_fail = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zero(zero), .less(less), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: exact signed arithmetic in a wider type; overflow means the exact
  // result does not survive truncation to W bits.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] o, output logic l, output logic v,
                                output logic e, output int lat);
    logic signed [W+1:0] ex;
    int sh;
    sh = int'(b % 64);
    o = '0; l = 1'b0; v = 1'b0; e = 1'b0; lat = 0;
    case (op)
      4'd0: o = a & b;
      4'd1: o = a | b;
      4'd3: o = a ^ b;
      4'd2: begin
        ex = $signed(a) + $signed(b);
        o = ex[W-1:0];
        v = (ex != $signed(o));
      end
      4'd6: begin
        ex = $signed(a) - $signed(b);
        o = ex[W-1:0];
        v = (ex != $signed(o));
        l = ($signed(a) < $signed(b));
      end
      4'd7: begin
        l = ($signed(a) < $signed(b));
        o = l ? 64'd1 : 64'd0;
      end
      4'd4: o = a >> sh;
      4'd5: o = $signed(a) >>> sh;
      4'd12: o = a << sh;
`ifdef SEQ_ALU_MUL_EN
      4'd8: begin
        o = a * b;
        lat = W;
      end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    logic [W-1:0] r;
    case ($urandom_range(0, 5))
      0: r = '0;
      1: r = 64'h8000_0000_0000_0000;
      2: r = '1;
      3: r = 64'h7FFF_FFFF_FFFF_FFFF;
      4: r = W'($urandom_range(0, 70));
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  // Drive one request (called #1 after a rising edge); returns edges from accept to out_valid.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic rdy_busy, output logic tmo);
    int guard;
    alu_op = op; in1 = a; in2 = b; in_valid = 1'b1;
    rdy_busy = 1'b0; guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op = 4'($urandom); in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_busy = 1'b1;
      @(posedge clk); #1; lat++;
    end
    tmo = !out_valid;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({out_valid, zero, less, ovf, err, out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 0", {out_valid, zero, less, ovf, err, out});
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_sub_flags();
    int lat; logic rb, tmo;
    issue(4'd6, 64'd5, 64'd5, lat, rb, tmo);
    n_chk++;
    if (tmo || {out, zero, less, ovf, err} !== {64'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_equal got out=%h z=%b l=%b v=%b e=%b required out=0 z=1 l=0 v=0 e=0",
               out, zero, less, ovf, err);
    end
    retire();
    issue(4'd6, 64'h8000_0000_0000_0000, 64'd1, lat, rb, tmo);
    n_chk++;
    if (tmo || {out, zero, less, ovf, err} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_min_minus_one got out=%h z=%b l=%b v=%b e=%b required out=7fffffffffffffff z=0 l=1 v=1 e=0",
               out, zero, less, ovf, err);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops [3];
    logic [W-1:0] as [3];
    logic [W-1:0] bs [3];
    logic [W-1:0] exp_o [3];
    ops[0] = 4'd2;  as[0] = 64'd3;                   bs[0] = 64'd4;  exp_o[0] = 64'd7;
    ops[1] = 4'd12; as[1] = 64'd1;                   bs[1] = 64'd65; exp_o[1] = 64'd2;
    ops[2] = 4'd5;  as[2] = 64'hF000_0000_0000_0000; bs[2] = 64'd4;  exp_o[2] = 64'hFF00_0000_0000_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_op = ops[i]; in1 = as[i]; in2 = bs[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || out !== exp_o[i]) begin
        n_fail++;
        $display("FAIL b2b_op%0d got valid=%b out=%h required valid=1 out=%h", i, out_valid, out, exp_o[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drain got valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat; logic rb, tmo;
    int bad;
    issue(4'd0, 64'hF0, 64'h3C, lat, rb, tmo);
    alu_op = 4'd2; in1 = 64'd100; in2 = 64'd23; in_valid = 1'b1;
    bad = tmo ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out !== 64'h30 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold got %0d bad cycles (out=%h valid=%b ready=%b) required 0, out=30",
               bad, out, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || out !== 64'd123) begin
      n_fail++;
      $display("FAIL backpressure_direct_accept got valid=%b out=%h required valid=1 out=7b", out_valid, out);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_to_idle got valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [7];
    logic [W-1:0] eo; logic el, ev, ee; int elat;
    int lat; logic rb, tmo;
    ops[0] = 4'd15; ops[1] = 4'd9; ops[2] = 4'd10; ops[3] = 4'd11;
    ops[4] = 4'd13; ops[5] = 4'd14; ops[6] = 4'd8;
    for (int i = 0; i < 7; i++) begin
      model(ops[i], 64'h1234, 64'h5, eo, el, ev, ee, elat);
      issue(ops[i], 64'h1234, 64'h5, lat, rb, tmo);
      n_chk++;
      if (tmo || lat != elat || {out, zero, less, ovf, err} !== {eo, (eo == '0), el, ev, ee}) begin
        n_fail++;
        $display("FAIL illegal_op%0d got out=%h z=%b e=%b lat=%0d required out=%h z=%b e=%b lat=%0d",
                 ops[i], out, zero, err, lat, eo, (eo == '0), ee, elat);
      end
      retire();
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] eo; logic el, ev, ee; int elat;
    int lat; logic rb, tmo;
    model(4'd8, '1, 64'd3, eo, el, ev, ee, elat);
    issue(4'd8, '1, 64'd3, lat, rb, tmo);
    n_chk++;
    if (tmo || lat != elat || rb !== 1'b0 || {out, zero, less, ovf, err} !== {eo, (eo == '0), el, ev, ee}) begin
      n_fail++;
      $display("FAIL mul_ones_x3 got out=%h e=%b lat=%0d ready_in_busy=%b required out=%h e=%b lat=%0d ready_in_busy=0",
               out, err, lat, rb, eo, ee, elat);
    end
    retire();
  endtask

  task automatic test_reset_mid();
    logic pulse;
    alu_op = 4'd8; in1 = '1; in2 = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, zero, less, ovf, err, out} !== '0) begin
      n_fail++;
      $display("FAIL reset_async got %h required 0", {out_valid, zero, less, ovf, err, out});
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    pulse = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulse = 1'b1;
    end
    n_chk++;
    if (pulse !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_release got valid_pulse=%b ready=%b required 0 and 1", pulse, in_ready);
    end
  endtask

  task automatic test_random();
    logic [3:0] op; logic [W-1:0] a, b;
    logic [W-1:0] eo; logic el, ev, ee; int elat;
    int lat; logic rb, tmo;
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
      a = rnd_opnd(); b = rnd_opnd();
      model(op, a, b, eo, el, ev, ee, elat);
      issue(op, a, b, lat, rb, tmo);
      n_chk++;
      if (tmo || lat != elat || rb !== 1'b0 || {out, zero, less, ovf, err} !== {eo, (eo == '0), el, ev, ee}) begin
        n_fail++;
        $display("FAIL rand%0d op=%h a=%h b=%h got out=%h z%b l%b v%b e%b lat=%0d required out=%h z%b l%b v%b e%b lat=%0d",
                 i, op, a, b, out, zero, less, ovf, err, lat, eo, (eo == '0), el, ev, ee, elat);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      n_chk++;
      if (out_valid !== 1'b1 || out !== eo) begin
        n_fail++;
        $display("FAIL rand%0d_stall got valid=%b out=%h required valid=1 out=%h", i, out_valid, out, eo);
      end
      retire();
    end
  endtask

  initial begin
    test_reset();
    test_sub_flags();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_mul();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
